// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encodings and default width for the serial subtractor
package serial_subtractor_pkg;
  localparam int DEF_WIDTH = 32;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;
endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// half_subtractor: one-bit half subtractor, Dout = X - Y with borrow Bout
// Ports:
//   X, Y  : minuend / subtrahend bits
//   Dout  : difference bit X^Y
//   Bout  : borrow out ~X&Y
module half_subtractor (
  output logic Dout,
  output logic Bout,
  input  logic X,
  input  logic Y
);
  assign Dout = X ^ Y;
  assign Bout = ~X & Y;
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement D = A - B, LSB first, one bit per clock
// Ports:
//   CLK, RST  : clock (rising edge), synchronous active-high reset
//   START     : request; A and B are captured when accepted (IDLE or DONE)
//   A, B      : minuend, subtrahend
//   D         : difference, held until the next completion or reset
//   BO, V, Z  : borrow out, signed overflow, zero flag (registered with D)
//   BUSY      : high for the WIDTH cycles of an operation
//   DONE      : one-cycle pulse when D/BO/V/Z are updated
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic             V,
  output logic             Z,
  output logic             BUSY,
  output logic             DONE
);
  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_borrow;
  logic               r_sa;
  logic               r_sb;
  logic               w_x;
  logic               w_b1;
  logic               w_b2;
  logic               w_d;
  logic               w_bo;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_res;

  // Full subtractor for the current bit: two half subtractors plus an OR on the borrows
  half_subtractor u_hs0 (.Dout(w_x), .Bout(w_b1), .X(r_a[0]), .Y(r_b[0]));
  half_subtractor u_hs1 (.Dout(w_d), .Bout(w_b2), .X(w_x),    .Y(r_borrow));
  assign w_bo = w_b1 | w_b2;

  // New difference bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB
  assign w_res = {w_d, r_res[WIDTH-1:1]};

  always_comb begin
    w_accept = (r_state != ST_BUSY) && START;
    w_last   = (r_state == ST_BUSY) && (r_cnt == CNT_W'(WIDTH - 1));
    w_next   = w_accept ? ST_BUSY :
               (r_state == ST_BUSY) ? (w_last ? ST_DONE : ST_BUSY) : ST_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      D        <= '0;
      BO       <= 1'b0;
      V        <= 1'b0;
      Z        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a      <= A;
        r_b      <= B;
        r_borrow <= 1'b0;
        r_cnt    <= '0;
        r_sa     <= A[WIDTH-1];
        r_sb     <= B[WIDTH-1];
      end else if (r_state == ST_BUSY) begin
        r_a      <= {1'b0, r_a[WIDTH-1:1]};
        r_b      <= {1'b0, r_b[WIDTH-1:1]};
        r_borrow <= w_bo;
        r_res    <= w_res;
        r_cnt    <= r_cnt + CNT_W'(1);
        if (w_last) begin
          D  <= w_res;
          BO <= w_bo;
          V  <= (r_sa ^ r_sb) & (r_sa ^ w_d);
          Z  <= ~|w_res;
        end
      end
    end
  end

  assign BUSY = (r_state == ST_BUSY);
  assign DONE = (r_state == ST_DONE);
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor
module tb_serial_subtractor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] d;
  logic        bo, v, z, busy, done;
  int          n_cmp = 0;
  int          n_err = 0;

  serial_subtractor #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK(clk), .RST(rst), .START(start), .A(a), .B(b),
    .D(d), .BO(bo), .V(v), .Z(z), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  // Drives one operation from a negedge and waits (bounded) for DONE; returns what was seen
  task automatic do_op(input logic [31:0] ai, input logic [31:0] bi, output logic [31:0] od,
                       output logic obo, output logic ov, output logic oz,
                       output int lat, output int nbusy, output logic both);
    a = ai; b = bi; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0; nbusy = 0; both = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      nbusy += int'(busy);
      both |= busy & done;
    end while (!done && lat < 100);
    od = d; obo = bo; ov = v; oz = z;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_d: got %h expected %h", d, 32'h0); end
    n_cmp++; if ({bo, v, z} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {bo, v, z}); end
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] od; logic obo, ov, oz, both; int lat, nb;
    do_op(32'd5, 32'd3, od, obo, ov, oz, lat, nb, both);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL basic_latency: got %0d expected 33", lat); end
    n_cmp++; if (nb !== 32) begin n_err++; $display("FAIL basic_busy_cycles: got %0d expected 32", nb); end
    n_cmp++; if (both !== 1'b0) begin n_err++; $display("FAIL basic_busy_and_done: got %b expected 0", both); end
    n_cmp++; if (od !== 32'd2) begin n_err++; $display("FAIL basic_d: got %h expected %h", od, 32'd2); end
    n_cmp++; if ({obo, ov, oz} !== 3'b000) begin n_err++; $display("FAIL basic_flags: got %b expected 000", {obo, ov, oz}); end
  endtask

  task automatic test_negative();
    logic [31:0] od; logic obo, ov, oz, both; int lat, nb;
    do_op(32'd3, 32'd5, od, obo, ov, oz, lat, nb, both);
    n_cmp++; if (od !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL neg_d: got %h expected %h", od, 32'hFFFF_FFFE); end
    n_cmp++; if ({obo, ov, oz} !== 3'b100) begin n_err++; $display("FAIL neg_flags: got %b expected 100", {obo, ov, oz}); end
  endtask

  task automatic test_overflow();
    logic [31:0] od; logic obo, ov, oz, both; int lat, nb;
    do_op(32'h8000_0000, 32'h1, od, obo, ov, oz, lat, nb, both);
    n_cmp++; if (od !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL ovf1_d: got %h expected %h", od, 32'h7FFF_FFFF); end
    n_cmp++; if ({obo, ov, oz} !== 3'b010) begin n_err++; $display("FAIL ovf1_flags: got %b expected 010", {obo, ov, oz}); end
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, od, obo, ov, oz, lat, nb, both);
    n_cmp++; if (od !== 32'h8000_0000) begin n_err++; $display("FAIL ovf2_d: got %h expected %h", od, 32'h8000_0000); end
    n_cmp++; if ({obo, ov, oz} !== 3'b110) begin n_err++; $display("FAIL ovf2_flags: got %b expected 110", {obo, ov, oz}); end
  endtask

  task automatic test_zero();
    logic [31:0] od; logic obo, ov, oz, both; int lat, nb;
    do_op(32'h0000_1234, 32'h0000_1234, od, obo, ov, oz, lat, nb, both);
    n_cmp++; if (od !== 32'h0) begin n_err++; $display("FAIL zero_d: got %h expected %h", od, 32'h0); end
    n_cmp++; if ({obo, ov, oz} !== 3'b001) begin n_err++; $display("FAIL zero_flags: got %b expected 001", {obo, ov, oz}); end
  endtask

  task automatic test_hold();
    int n;
    repeat (5) @(negedge clk);
    n_cmp++; if ({d, z} !== {32'h0, 1'b1}) begin n_err++; $display("FAIL hold_idle: got d=%h z=%b expected d=0 z=1", d, z); end
    a = 32'd9; b = 32'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, d, z} !== {1'b1, 32'h0, 1'b1}) begin n_err++; $display("FAIL hold_mid_op: got busy=%b d=%h z=%b expected busy=1 d=0 z=1", busy, d, z); end
    n = 3;
    while (!done && n < 100) begin @(negedge clk); n++; end
    n_cmp++; if (n !== 33) begin n_err++; $display("FAIL hold_latency: got %0d expected 33", n); end
    n_cmp++; if (d !== 32'd5) begin n_err++; $display("FAIL hold_result: got %h expected %h", d, 32'd5); end
  endtask

  task automatic test_ignore_start();
    int dc = 0; int nd = 0; logic [31:0] dd = '0;
    a = 32'd20; b = 32'd7; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start = (c == 5 || c == 10);
      a = 32'(c * 1000); b = 32'd1;
      @(negedge clk);
      if (done) begin nd++; if (dc == 0) begin dc = c; dd = d; end end
    end
    n_cmp++; if (dc !== 33) begin n_err++; $display("FAIL ignore_done_cycle: got %0d expected 33", dc); end
    n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL ignore_done_count: got %0d expected 1", nd); end
    n_cmp++; if (dd !== 32'd13) begin n_err++; $display("FAIL ignore_d: got %h expected %h", dd, 32'd13); end
  endtask

  task automatic test_reset_mid();
    int nd = 0;
    logic [31:0] od; logic obo, ov, oz, both; int lat, nb;
    a = 32'd100; b = 32'd1; start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      start = (c == 5 || c == 10);
      a = 32'(c); b = 32'(c + 2);
      rst = (c == 16);
      @(negedge clk);
      if (c == 16) begin
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
      end
      if (c == 17) begin
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rstmid_d: got %h expected %h", d, 32'h0); end
        n_cmp++; if ({bo, v, z, busy, done} !== 5'b0) begin n_err++; $display("FAIL rstmid_flags: got %b expected 00000", {bo, v, z, busy, done}); end
      end
      if (c >= 17 && done) nd++;
    end
    n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d expected 0", nd); end
    do_op(32'd9, 32'd4, od, obo, ov, oz, lat, nb, both);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL rstmid_new_latency: got %0d expected 33", lat); end
    n_cmp++; if (od !== 32'd5) begin n_err++; $display("FAIL rstmid_new_d: got %h expected %h", od, 32'd5); end
  endtask

  task automatic test_back_to_back();
    int d1 = 0; int d2 = 0; int nd = 0; logic b34 = 1'b0;
    logic [31:0] v1 = '0; logic [31:0] v2 = '0;
    a = 32'd10; b = 32'd1; start = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk); #1;
      if (c == 40) start = 1'b0;
      @(negedge clk);
      if (c == 34) b34 = busy;
      if (done) begin
        nd++;
        if (nd == 1) begin d1 = c; v1 = d; end
        if (nd == 2) begin d2 = c; v2 = d; end
      end
    end
    n_cmp++; if (d1 !== 33) begin n_err++; $display("FAIL b2b_first_done: got %0d expected 33", d1); end
    n_cmp++; if (v1 !== 32'd9) begin n_err++; $display("FAIL b2b_first_d: got %h expected %h", v1, 32'd9); end
    n_cmp++; if (b34 !== 1'b1) begin n_err++; $display("FAIL b2b_busy34: got %b expected 1", b34); end
    n_cmp++; if (d2 !== 66) begin n_err++; $display("FAIL b2b_second_done: got %0d expected 66", d2); end
    n_cmp++; if (v2 !== 32'd9) begin n_err++; $display("FAIL b2b_second_d: got %h expected %h", v2, 32'd9); end
    n_cmp++; if (nd !== 2) begin n_err++; $display("FAIL b2b_done_count: got %0d expected 2", nd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_overflow();
    test_zero();
    test_hold();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
